// File: rtl/wb_arb_pkg.sv
// Shared types and field widths for the Wishbone-to-SPI arbiter tile.
// The ABORT state only exists when WB_SPI_ARB_TIMEOUT_EN is defined.
package wb_arb_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  localparam int TMO_W = 8;

`ifdef WB_SPI_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1
  } arb_state_t;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin one-hot selector: the first requester at or
// after index ptr (wrapping) wins; no request gives an all-zero grant.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [PTR_W-1:0] idx;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt = '0;
    idx = '0;
    // Walk from farthest to nearest so the nearest requester is written last.
    for (int off = N - 1; off >= 0; off--) begin
      idx = PTR_W'((int'(ptr) + off) % N);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_spi_arbiter.sv
// Round-robin arbiter letting NR_MASTERS Wishbone masters share one SPI slave.
// Define WB_SPI_ARB_TIMEOUT_EN to add the stall timeout and ABORT state.
module wb_spi_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NR_MASTERS     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADR_W*NR_MASTERS-1:0] m_adr_i,
  input  logic [DAT_W*NR_MASTERS-1:0] m_dat_i,
  input  logic [SEL_W*NR_MASTERS-1:0] m_sel_i,
  input  logic [NR_MASTERS-1:0]       m_cyc_i,
  input  logic [NR_MASTERS-1:0]       m_stb_i,
  input  logic [NR_MASTERS-1:0]       m_we_i,
  output logic [NR_MASTERS-1:0]       m_ack_o,
  output logic [NR_MASTERS-1:0]       m_err_o,
  output logic [DAT_W-1:0]            m_dat_o,
  output logic [ADR_W-1:0]            s_adr_o,
  output logic [DAT_W-1:0]            s_dat_o,
  output logic [SEL_W-1:0]            s_sel_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  input  logic [DAT_W-1:0]            s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  output logic [NR_MASTERS-1:0]       grant_o
);

  localparam int PTR_W = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;

  arb_state_t             state;
  logic [NR_MASTERS-1:0]  grant_q;
  logic [PTR_W-1:0]       owner;
  logic [PTR_W-1:0]       ptr;
  logic [NR_MASTERS-1:0]  rr_gnt;
  logic [PTR_W-1:0]       rr_idx;
  logic [PTR_W-1:0]       next_ptr;
  logic                   busy;
  logic                   own_cyc;

  rr_arbiter #(
    .N     (NR_MASTERS),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (m_cyc_i),
    .ptr (ptr),
    .gnt (rr_gnt)
  );

  always_comb begin
    rr_idx = '0;
    for (int k = 0; k < NR_MASTERS; k++) begin
      if (rr_gnt[k]) rr_idx = PTR_W'(k);
    end
  end

  assign next_ptr = (owner == PTR_W'(NR_MASTERS - 1)) ? '0 : owner + 1'b1;
  assign busy     = (state == ST_BUSY);
  assign own_cyc  = m_cyc_i[owner];
  assign grant_o  = grant_q;
  assign m_dat_o  = s_dat_i;

  // Request path is a pure mux of the owner; everything is gated off outside BUSY.
  assign s_cyc_o = busy & own_cyc;
  assign s_stb_o = busy & m_stb_i[owner];
  assign s_we_o  = busy & m_we_i[owner];
  assign s_adr_o = busy ? m_adr_i[owner*ADR_W +: ADR_W] : '0;
  assign s_dat_o = busy ? m_dat_i[owner*DAT_W +: DAT_W] : '0;
  assign s_sel_o = busy ? m_sel_i[owner*SEL_W +: SEL_W] : '0;
  assign m_ack_o = (s_cyc_o & s_ack_i) ? grant_q : '0;

`ifdef WB_SPI_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_err;

  assign m_err_o = ((s_cyc_o & s_err_i) ? grant_q : '0) | (tmo_err ? grant_q : '0);
`else
  assign m_err_o = (s_cyc_o & s_err_i) ? grant_q : '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      owner   <= '0;
      ptr     <= '0;
`ifdef WB_SPI_ARB_TIMEOUT_EN
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
`endif
    end else begin
`ifdef WB_SPI_ARB_TIMEOUT_EN
      tmo_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (|m_cyc_i) begin
            state   <= ST_BUSY;
            grant_q <= rr_gnt;
            owner   <= rr_idx;
          end
        end
        ST_BUSY: begin
          // Release wins over everything else, including a timeout in the same cycle.
          if (!own_cyc) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            ptr     <= next_ptr;
`ifdef WB_SPI_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
          end else if (s_ack_i || s_err_i) begin
            tmo_cnt <= '0;
          end else if (s_stb_o) begin
            if (tmo_cnt == TMO_LIMIT - 1'b1) begin
              state   <= ST_ABORT;
              tmo_cnt <= '0;
              tmo_err <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
        end
`ifdef WB_SPI_ARB_TIMEOUT_EN
        ST_ABORT: begin
          if (!own_cyc) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            ptr     <= next_ptr;
          end
        end
`endif
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_spi_arbiter.sv
// Self-checking bench for wb_spi_arbiter: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_wb_spi_arbiter;

  localparam int N = 2;
`ifdef WB_SPI_ARB_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk, rst;
  logic [63:0]   m_adr_i, m_dat_i;
  logic [7:0]    m_sel_i;
  logic [N-1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [N-1:0]  m_ack_o, m_err_o, grant_o;
  logic [31:0]   m_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]    s_sel_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;

  wb_spi_arbiter #(.NR_MASTERS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: owner index (-1 = nobody), rotating pointer, stall count.
  int m_owner, m_ptr, m_cnt;
  bit m_abort, m_errp;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_abort = 0; m_errp = 0;
  endtask

  task automatic model_check(input string tag);
    logic [N-1:0] eg, eack, eerr;
    logic [70:0]  ereq;
    bit           serving;
    serving = (m_owner >= 0) && !m_abort;
    eg   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    ereq = '0;
    eack = '0;
    eerr = m_errp ? eg : '0;
    if (serving) begin
      ereq = {m_cyc_i[m_owner], m_stb_i[m_owner], m_we_i[m_owner], m_sel_i[4*m_owner +: 4],
              m_adr_i[32*m_owner +: 32], m_dat_i[32*m_owner +: 32]};
      if (m_cyc_i[m_owner] && s_ack_i) eack = eg;
      if (m_cyc_i[m_owner] && s_err_i) eerr = eerr | eg;
    end
    check({tag, " grant"}, 96'(grant_o), 96'(eg));
    check({tag, " s_req"}, 96'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}), 96'(ereq));
    check({tag, " ack"}, 96'(m_ack_o), 96'(eack));
    check({tag, " err"}, 96'(m_err_o), 96'(eerr));
    check({tag, " m_dat"}, 96'(m_dat_o), 96'(s_dat_i));
  endtask

  // Advance the model by one clock edge using the inputs of the cycle just ending.
  task automatic model_step();
    m_errp = 0;
    if (m_owner < 0) begin
      for (int off = 0; off < N; off++) begin
        if (m_owner < 0 && m_cyc_i[(m_ptr + off) % N]) m_owner = (m_ptr + off) % N;
      end
    end else if (!m_cyc_i[m_owner]) begin
      m_ptr = (m_owner + 1) % N;
      m_owner = -1; m_abort = 0; m_cnt = 0;
    end else if (TMO_EN && !m_abort) begin
      if (s_ack_i || s_err_i) m_cnt = 0;
      else if (m_stb_i[m_owner]) begin
        m_cnt++;
        if (m_cnt == TMO) begin m_abort = 1; m_errp = 1; m_cnt = 0; end
      end
    end
  endtask

  task automatic drive(input logic [1:0] cyc, input logic [1:0] stb, input logic ack);
    m_cyc_i = cyc; m_stb_i = stb; s_ack_i = ack; s_err_i = 1'b0;
    m_adr_i = {32'h0000_0020, 32'h0000_0010};
    m_dat_i = {32'hBBBB_0001, 32'hAAAA_0000};
    m_sel_i = 8'hF3;
    m_we_i  = 2'b10;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 2'b00, 1'b0);
    s_dat_i = 32'h0;
    #1;
    check({tag, " rst grant"}, 96'(grant_o), 96'(0));
    check({tag, " rst s_out"}, 96'({s_cyc_o, s_stb_o, s_adr_o}), 96'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct packed {
    logic [1:0]  cyc;
    logic        ack;
    logic [1:0]  e_grant;
    logic        e_scyc;
    logic [31:0] e_adr;
    logic [1:0]  e_ack;
  } vec_t;

  vec_t vecs[14];
  logic [5:0] err_trace;
  bit         seen_err;

  initial begin
    vecs[0]  = '{2'b01, 1'b0, 2'b00, 1'b0, 32'h00, 2'b00};
    vecs[1]  = '{2'b01, 1'b1, 2'b01, 1'b1, 32'h10, 2'b01};
    vecs[2]  = '{2'b00, 1'b0, 2'b01, 1'b0, 32'h10, 2'b00};
    vecs[3]  = '{2'b10, 1'b0, 2'b00, 1'b0, 32'h00, 2'b00};
    vecs[4]  = '{2'b10, 1'b1, 2'b10, 1'b1, 32'h20, 2'b10};
    vecs[5]  = '{2'b11, 1'b0, 2'b10, 1'b1, 32'h20, 2'b00};
    vecs[6]  = '{2'b01, 1'b1, 2'b10, 1'b0, 32'h20, 2'b00};
    vecs[7]  = '{2'b01, 1'b1, 2'b00, 1'b0, 32'h00, 2'b00};
    vecs[8]  = '{2'b11, 1'b1, 2'b01, 1'b1, 32'h10, 2'b01};
    vecs[9]  = '{2'b10, 1'b1, 2'b01, 1'b0, 32'h10, 2'b00};
    vecs[10] = '{2'b10, 1'b0, 2'b00, 1'b0, 32'h00, 2'b00};
    vecs[11] = '{2'b10, 1'b0, 2'b10, 1'b1, 32'h20, 2'b00};
    vecs[12] = '{2'b00, 1'b0, 2'b10, 1'b0, 32'h20, 2'b00};
    vecs[13] = '{2'b00, 1'b0, 2'b00, 1'b0, 32'h00, 2'b00};

    rst = 1'b1;
    drive(2'b00, 2'b00, 1'b0);
    s_dat_i = 32'h0;
    model_reset();

    // Directed table, one row per clock cycle.
    apply_reset("table");
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].cyc, vecs[i].cyc, vecs[i].ack);
      s_dat_i = 32'hC0DE_0000 + 32'(i);
      #1;
      check($sformatf("vec%0d grant", i), 96'(grant_o), 96'(vecs[i].e_grant));
      check($sformatf("vec%0d s_cyc", i), 96'(s_cyc_o), 96'(vecs[i].e_scyc));
      check($sformatf("vec%0d s_adr", i), 96'(s_adr_o), 96'(vecs[i].e_adr));
      check($sformatf("vec%0d ack", i), 96'(m_ack_o), 96'(vecs[i].e_ack));
      check($sformatf("vec%0d m_dat", i), 96'(m_dat_o), 96'(32'hC0DE_0000 + 32'(i)));
      @(negedge clk);
    end

    // Simultaneous requests after reset, then pointer wrap back to master 0.
    apply_reset("simul");
    drive(2'b11, 2'b11, 1'b0); #1;
    check("simul idle grant", 96'(grant_o), 96'(2'b00));
    @(negedge clk); #1;
    check("simul first grant", 96'(grant_o), 96'(2'b01));
    check("simul s_adr", 96'(s_adr_o), 96'(32'h10));
    s_ack_i = 1'b1; #1;
    check("simul ack0", 96'(m_ack_o), 96'(2'b01));
    @(negedge clk);
    drive(2'b10, 2'b10, 1'b0);
    for (int w = 0; w < 2 && grant_o != 2'b10; w++) begin @(negedge clk); #1; end
    check("simul second grant", 96'(grant_o), 96'(2'b10));
    s_ack_i = 1'b1; #1;
    check("simul ack1", 96'(m_ack_o), 96'(2'b10));
    @(negedge clk); drive(2'b00, 2'b00, 1'b0);
    @(negedge clk); drive(2'b11, 2'b11, 1'b0); #1;
    check("simul idle2", 96'(grant_o), 96'(2'b00));
    @(negedge clk); #1;
    check("simul ptr0", 96'(grant_o), 96'(2'b01));

    // Fairness: both masters keep requesting; grants must alternate.
    for (int t = 0; t < 8; t++) begin
      for (int w = 0; w < 4 && grant_o == 2'b00; w++) begin @(negedge clk); #1; end
      check($sformatf("fair t%0d", t), 96'(grant_o), 96'(2'b01 << (t % 2)));
      s_ack_i = 1'b1; #1;
      check($sformatf("fair ack t%0d", t), 96'(m_ack_o), 96'(2'b01 << (t % 2)));
      @(negedge clk); drive(2'b11 & ~grant_o, 2'b11 & ~grant_o, 1'b0);
      @(negedge clk); drive(2'b11, 2'b11, 1'b0); #1;
    end

    // Master 1 drops before ack; a late ack must not reach anyone.
    apply_reset("drop");
    drive(2'b10, 2'b10, 1'b0);
    @(negedge clk); #1;
    check("drop grant", 96'(grant_o), 96'(2'b10));
    @(negedge clk); drive(2'b00, 2'b00, 1'b0);
    @(negedge clk); s_ack_i = 1'b1; #1;
    check("drop idle", 96'({grant_o, s_cyc_o}), 96'(0));
    check("drop late ack", 96'({m_ack_o, m_err_o}), 96'(0));

`ifdef WB_SPI_ARB_TIMEOUT_EN
    // Slave never acks: error pulse 4 cycles after grant, then ABORT.
    apply_reset("tmo");
    drive(2'b11, 2'b11, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      err_trace[k-1] = m_err_o[0];
      check($sformatf("tmo m1 err k%0d", k), 96'(m_err_o[1]), 96'(0));
    end
    check("tmo err pulse", 96'(err_trace), 96'(6'b010000));
    check("tmo abort s_cyc", 96'({s_cyc_o, grant_o}), 96'({1'b0, 2'b01}));
    @(negedge clk); drive(2'b10, 2'b10, 1'b0);
    for (int w = 0; w < 2 && grant_o != 2'b10; w++) begin @(negedge clk); #1; end
    check("tmo other granted", 96'(grant_o), 96'(2'b10));
`else
    // Without the timeout, BUSY waits for the slave indefinitely.
    apply_reset("stall");
    drive(2'b01, 2'b01, 1'b0);
    seen_err = 0;
    repeat (40) begin @(negedge clk); #1; if (m_err_o != 0) seen_err = 1; end
    check("stall no err", 96'(seen_err), 96'(0));
    check("stall held", 96'({grant_o, s_cyc_o}), 96'({2'b01, 1'b1}));
`endif

    // Asynchronous reset mid-transfer.
    apply_reset("arst");
    drive(2'b11, 2'b11, 1'b0);
    @(negedge clk); #1;
    check("arst busy", 96'(grant_o), 96'(2'b01));
    s_ack_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst grant", 96'(grant_o), 96'(0));
    check("arst outs", 96'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}), 96'(0));
    check("arst resp", 96'({m_ack_o, m_err_o}), 96'(0));
    @(negedge clk); rst = 1'b0; s_ack_i = 1'b0; #1;
    check("arst post idle", 96'(grant_o), 96'(0));
    @(negedge clk); #1;
    check("arst first grant", 96'(grant_o), 96'(2'b01));

    // Randomized traffic against the reference model.
    apply_reset("rand");
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] cyc, stb;
      cyc = m_cyc_i;
      for (int k = 0; k < N; k++) begin
        if (cyc[k]) cyc[k] = ($urandom_range(0, 5) != 0);
        else        cyc[k] = ($urandom_range(0, 2) == 0);
        stb[k] = cyc[k] & ($urandom_range(0, 3) != 0);
      end
      m_cyc_i = cyc;
      m_stb_i = stb;
      m_we_i  = N'($urandom);
      m_sel_i = 8'($urandom);
      m_adr_i = {$urandom, $urandom};
      m_dat_i = {$urandom, $urandom};
      s_dat_i = $urandom;
      s_ack_i = ($urandom_range(0, 2) == 0);
      s_err_i = ($urandom_range(0, 15) == 0);
      #1;
      model_check($sformatf("rand c%0d", c));
      model_step();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_spi_arbiter.md
WB_SPI_ARBITER -- requirements
Module: wb_spi_arbiter

Interface
REQ-001 SHALL have parameter NR_MASTERS, default 2, number of Wishbone requesters sharing one SPI slave.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, stall limit in cycles (8-bit counter, range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports m_adr_i/m_dat_i  input  32*NR_MASTERS  flattened per-master address/write data; master k occupies bits [32k+31:32k].
REQ-006 SHALL have port m_sel_i  input  4*NR_MASTERS  byte selects; m_cyc_i, m_stb_i, m_we_i  input  NR_MASTERS  per-master controls.
REQ-007 SHALL have ports m_ack_o, m_err_o  output  NR_MASTERS  per-master responses; m_dat_o  output  32  shared read data.
REQ-008 SHALL have ports s_adr_o, s_dat_o  output  32; s_sel_o  output  4; s_cyc_o, s_stb_o, s_we_o  output  1: slave request side.
REQ-009 SHALL have ports s_dat_i  input  32; s_ack_i, s_err_i  input  1: slave response side.
REQ-010 SHALL have port grant_o  output  NR_MASTERS  one-hot current owner, all-zero when idle.

Function
REQ-011 SHALL implement states IDLE, BUSY, ABORT.
REQ-012 IDLE: when any m_cyc_i is high, SHALL register a one-hot grant and enter BUSY on the next edge; arbitration latency exactly 1 cycle.
REQ-013 Grant SHALL be round-robin: search starts at index ptr, wrapping from NR_MASTERS-1 to 0; ptr resets to 0.
REQ-014 On leaving BUSY or ABORT, ptr SHALL become (granted index + 1) mod NR_MASTERS.
REQ-015 BUSY: s_adr/dat/sel/we/cyc/stb_o SHALL follow the granted master combinationally; non-granted masters are ignored.
REQ-016 BUSY: s_ack_i/s_err_i SHALL route combinationally to the granted master only; other m_ack_o/m_err_o bits are 0.
REQ-017 m_dat_o SHALL equal s_dat_i at all times.
REQ-018 Granted master deasserting m_cyc_i SHALL return the FSM to IDLE on the next edge, including mid-transfer; no new grant is issued in that cycle.
REQ-019 Outside BUSY, all s_* request outputs SHALL be 0 and all m_ack_o/m_err_o SHALL be 0, except as REQ-021 requires.
REQ-020 A new request arriving together with a release SHALL be considered only in the following IDLE cycle.

Configuration
REQ-021 With WB_SPI_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL increment in every BUSY cycle with s_stb_o=1 and no s_ack_i/s_err_i. It SHALL clear on ack, err, or state exit. On reaching TIMEOUT_CYCLES, it SHALL pulse m_err_o of the owner for 1 cycle and enter ABORT. ABORT holds s_cyc_o=0 until the owner drops m_cyc_i, then returns to IDLE.
REQ-022 Without WB_SPI_ARB_TIMEOUT_EN, the counter and ABORT state SHALL not exist, and BUSY SHALL wait indefinitely.

Reset
REQ-023 rst SHALL asynchronously force state IDLE, grant_o=0, ptr=0, and counter=0; consequently all s_* and m_ack_o/m_err_o outputs are 0.
REQ-024 rst asserted mid-transfer SHALL abort immediately, with no response delivered to any master.

Structure
REQ-025 A shared package wb_arb_pkg SHALL hold the state enum, the timeout counter width constant, and the Wishbone field widths (ADR 32, DAT 32, SEL 4).
REQ-026 The round-robin one-hot selector SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot gnt), reusable by other tile arbiters.

Verification
REQ-027 Single request: m_cyc_i=01, adr 0x0000_0010 -> grant_o=01 after 1 cycle, s_adr_o=0x10, ack returned to m_ack_o[0] only.
REQ-028 Simultaneous requests after reset: m_cyc_i=11 -> master 0 served first. After its release, master 1 is granted within 2 cycles, and ptr is 0 after master 1 releases.
REQ-029 Fairness: both masters requesting continuously for 8 transactions -> grants alternate 0,1,0,1,... with no master granted twice in a row.
REQ-030 Mid-transfer drop: master 1 drops m_cyc_i before ack -> next cycle IDLE, s_cyc_o=0, and a late s_ack_i is not routed to any master.
REQ-031 Timeout with WB_SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> m_err_o pulses high 1 cycle, 4 cycles after grant. Then s_cyc_o=0 until the owner releases, after which the other master is granted.
REQ-032 rst pulsed while BUSY -> all outputs 0 asynchronously, and the first post-reset grant goes to master 0.
